// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU load/store
// path (port 0) and the debug loader (port 1), with a fixed access latency.
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          start,

  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,

  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last;
  logic       sel;
  logic       any_req;
  logic       pick;
  logic       grant_now;
  logic       window_end;
  logic       rd_capture;

  // On a tie the port that was not served last wins; otherwise the sole requester.
  function automatic logic arb_pick(input logic req0, input logic req1, input logic last_port);
    if (req0 && req1) begin
      return !last_port;
    end
    return req1;
  endfunction

  assign any_req    = r0_req | r1_req;
  assign pick       = arb_pick(r0_req, r1_req, last);
  assign grant_now  = (state == IDLE) && any_req;
  assign window_end = (state == ACCESS) && (cnt == 4'd0);
  assign rd_capture = window_end && !mem_we;

  // Control: state, latency counter, round-robin pointer and handshake pulses
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last    <= 1'b1;
      sel     <= 1'b0;
      busy    <= 1'b0;
      r0_gnt  <= 1'b0;
      r1_gnt  <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      r0_gnt  <= 1'b0;
      r1_gnt  <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= ACCESS;
            busy   <= 1'b1;
            cnt    <= CNT_LOAD;
            sel    <= pick;
            r0_gnt <= !pick;
            r1_gnt <= pick;
            mem_en <= 1'b1;
            mem_we <= pick ? r1_we : r0_we;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= DONE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            r0_done <= !sel;
            r1_done <= sel;
            last    <= sel;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: request fields frozen at grant so requester changes mid-access are harmless
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_now) begin
      mem_addr  <= pick ? r1_addr  : r0_addr;
      mem_wdata <= pick ? r1_wdata : r0_wdata;
    end
  end

  // Read data is sampled on the last cycle of the window and held until the next read on that port
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else if (rd_capture) begin
      if (sel) begin
        r1_rdata <= mem_rdata;
      end else begin
        r0_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, multi-cycle corner sequences and random
// traffic checked cycle by cycle against a transaction-timestamp model.
module tb_dmem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } vec_t;

  logic        clk;
  logic        start;
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  wire  [1:0]  gnt_w;
  wire  [1:0]  done_w;
  wire  [31:0] rd0, rd1;
  wire         mem_en, mem_we, busy;
  wire  [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [256];

  logic        b_req;
  logic [31:0] b_addr;
  wire         b_gnt, b_done, b1_gnt, b1_done, b_mem_en, b_mem_we, b_busy;
  wire  [31:0] b_rdata, b1_rdata, b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model state
  logic        m_have, m_port, m_we, m_last;
  int          m_g, m_idle;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rd [2];
  logic [31:0] shadow [256];

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .start(start),
    .r0_req(req_v[0]), .r0_we(we_v[0]), .r0_addr(addr_v[0]), .r0_wdata(wdata_v[0]),
    .r0_gnt(gnt_w[0]), .r0_done(done_w[0]), .r0_rdata(rd0),
    .r1_req(req_v[1]), .r1_we(we_v[1]), .r1_addr(addr_v[1]), .r1_wdata(wdata_v[1]),
    .r1_gnt(gnt_w[1]), .r1_done(done_w[1]), .r1_rdata(rd1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .start(start),
    .r0_req(b_req), .r0_we(1'b0), .r0_addr(b_addr), .r0_wdata(32'h0),
    .r0_gnt(b_gnt), .r0_done(b_done), .r0_rdata(b_rdata),
    .r1_req(1'b0), .r1_we(1'b0), .r1_addr(32'h0), .r1_wdata(32'h0),
    .r1_gnt(b1_gnt), .r1_done(b1_done), .r1_rdata(b1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata   = mem[mem_addr[9:2]];
  assign b_mem_rdata = b_mem_addr ^ 32'h5A5A_0000;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0BAD_F00D;
    mem[4] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (mem_en && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor_step();
    int t;
    logic [1:0] e_gnt, e_done;
    logic e_en, e_busy, p;
    t = cyc;
    if (!start) begin
      chk("rst_ctl", 32'({gnt_w, done_w, mem_en, mem_we, busy}), 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_rd0", rd0, 32'h0);
      chk("rst_rd1", rd1, 32'h0);
      m_have = 1'b0; m_last = 1'b1; m_idle = 0;
      m_rd[0] = 32'h0; m_rd[1] = 32'h0; m_addr = 32'h0; m_wdata = 32'h0;
    end else begin
      if (m_have && t == m_g + LAT) begin
        if (m_we) shadow[m_addr[9:2]] = m_wdata;
        else      m_rd[m_port] = shadow[m_addr[9:2]];
      end
      e_en   = m_have && t >= m_g && t < m_g + LAT;
      e_busy = m_have && t >= m_g && t <= m_g + LAT;
      e_gnt  = 2'b00;
      e_done = 2'b00;
      if (m_have && t == m_g)       e_gnt[m_port]  = 1'b1;
      if (m_have && t == m_g + LAT) e_done[m_port] = 1'b1;
      chk("mon_gnt", 32'(gnt_w), 32'(e_gnt));
      chk("mon_done", 32'(done_w), 32'(e_done));
      chk("mon_mem_en", 32'(mem_en), 32'(e_en));
      chk("mon_mem_we", 32'(mem_we), 32'(e_en && m_we));
      chk("mon_busy", 32'(busy), 32'(e_busy));
      chk("mon_addr", mem_addr, m_addr);
      chk("mon_wdata", mem_wdata, m_wdata);
      chk("mon_rd0", rd0, m_rd[0]);
      chk("mon_rd1", rd1, m_rd[1]);
      if (t >= m_idle && req_v != 2'b00) begin
        p = (req_v == 2'b11) ? !m_last : req_v[1];
        m_have = 1'b1; m_g = t + 1; m_port = p; m_we = we_v[p];
        m_addr = addr_v[p]; m_wdata = wdata_v[p]; m_last = p;
        m_idle = m_g + LAT + 1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
    shadow[0] = 32'h0BAD_F00D;
    shadow[4] = 32'hDEAD_BEEF;
    m_have = 1'b0; m_last = 1'b1; m_idle = 0; m_g = 0;
    m_port = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
    m_rd[0] = 32'h0; m_rd[1] = 32'h0;
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  task automatic run_txn(input vec_t v, input string tag);
    int n, gc, dc;
    gc = -1; dc = -1;
    @(posedge clk); #1;
    req_v[v.port] = 1'b1; we_v[v.port] = v.we;
    addr_v[v.port] = v.addr; wdata_v[v.port] = v.wdata;
    n = cyc;
    for (int i = 0; i < 20 && dc < 0; i++) begin
      @(posedge clk); #2;
      if (gnt_w[v.port]) gc = cyc;
      if (done_w[v.port]) begin
        dc = cyc;
        req_v[v.port] = 1'b0;
      end
    end
    req_v[v.port] = 1'b0;
    chk($sformatf("%s_gnt_lat", tag), 32'(gc - n), 32'd1);
    chk($sformatf("%s_done_lat", tag), 32'(dc - n), 32'(LAT + 1));
    chk($sformatf("%s_rd0", tag), rd0, v.exp_rd0);
    chk($sformatf("%s_rd1", tag), rd1, v.exp_rd1);
    @(posedge clk); #2;
    chk($sformatf("%s_idle", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [11];
    int grants, dones, nd;
    int order [4];
    logic [1:0] pend, granted;
    logic gseen;

    start = 1'b1; req_v = 2'b00; we_v = 2'b00; b_req = 1'b0; b_addr = 32'h0;
    addr_v[0] = 32'h0; addr_v[1] = 32'h0; wdata_v[0] = 32'h0; wdata_v[1] = 32'h0;

    vecs[0]  = '{1'b0, 1'b0, 32'h10,  32'h0,         32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b1, 32'h20,  32'h12345678,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, 32'h20,  32'h0,         32'h12345678, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   32'h0,         32'h12345678, 32'h0BADF00D};
    vecs[4]  = '{1'b0, 1'b1, 32'h30,  32'hA5A5A5A5,  32'h12345678, 32'h0BADF00D};
    vecs[5]  = '{1'b1, 1'b0, 32'h30,  32'h0,         32'h12345678, 32'hA5A5A5A5};
    vecs[6]  = '{1'b1, 1'b1, 32'h10,  32'hCAFEF00D,  32'h12345678, 32'hA5A5A5A5};
    vecs[7]  = '{1'b0, 1'b0, 32'h10,  32'h0,         32'hCAFEF00D, 32'hA5A5A5A5};
    vecs[8]  = '{1'b0, 1'b0, 32'h3FC, 32'h0,         32'h0,        32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 1'b1, 32'h3FC, 32'hFFFFFFFF,  32'h0,        32'hA5A5A5A5};
    vecs[10] = '{1'b1, 1'b0, 32'h3FC, 32'h0,         32'h0,        32'hFFFFFFFF};

    // reset with random inputs
    #1 start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      req_v = 2'($urandom); we_v = 2'($urandom);
      addr_v[0] = $urandom; addr_v[1] = $urandom;
      wdata_v[0] = $urandom; wdata_v[1] = $urandom;
      b_req = 1'($urandom); b_addr = $urandom;
    end
    @(negedge clk);
    chk("rst_lat1_ctl", 32'({b_gnt, b_done, b_mem_en, b_mem_we, b_busy, b1_gnt, b1_done}), 32'h0);
    chk("rst_lat1_addr", b_mem_addr, 32'h0);
    chk("rst_lat1_wdata", b_mem_wdata, 32'h0);
    chk("rst_lat1_rdata", b_rdata | b1_rdata, 32'h0);

    // release with both requesting continuously
    @(posedge clk); #1;
    start = 1'b1; b_req = 1'b0;
    we_v = 2'b00; addr_v[0] = 32'h0; addr_v[1] = 32'h10;
    req_v = 2'b11;
    grants = 0; dones = 0;
    for (int i = 0; i < 60 && dones < 4; i++) begin
      @(posedge clk); #2;
      for (int p = 0; p < 2; p++) begin
        if (gnt_w[p]) begin
          chk("contend_no_overlap", 32'(dones), 32'(grants));
          if (grants < 4) order[grants] = p;
          grants++;
        end
      end
      if (done_w != 2'b00) dones++;
      for (int p = 0; p < 2; p++) req_v[p] = !done_w[p] && (dones < 4);
    end
    req_v = 2'b00;
    chk("contend_dones", 32'(dones), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("contend_order%0d", k), 32'(order[k]), 32'(k % 2));

    for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // reset during the second access cycle of an r0 read
    @(posedge clk); #1;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h10;
    gseen = 1'b0;
    for (int i = 0; i < 5 && !gseen; i++) begin
      @(posedge clk); #2;
      gseen = gnt_w[0];
    end
    chk("abort_gnt_seen", 32'(gseen), 32'd1);
    @(posedge clk); #3;
    start = 1'b0; req_v[0] = 1'b0;
    #1;
    chk("abort_outputs", 32'({gnt_w, done_w, mem_en, mem_we, busy}), 32'h0);
    @(posedge clk); #1;
    start = 1'b1;
    run_txn('{1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 32'h12345678}, "post_abort");
    @(posedge clk); #1;
    req_v = 2'b11; we_v = 2'b00; addr_v[0] = 32'h0; addr_v[1] = 32'h10;
    gseen = 1'b0;
    for (int i = 0; i < 5 && !gseen; i++) begin
      @(posedge clk); #2;
      if (gnt_w != 2'b00) begin
        gseen = 1'b1;
        chk("post_abort_tie", 32'(gnt_w), 32'h1);
        req_v[1] = 1'b0;
      end
    end
    chk("post_abort_tie_seen", 32'(gseen), 32'd1);
    req_v[1] = 1'b0;
    for (int i = 0; i < 10 && req_v[0]; i++) begin
      @(posedge clk); #2;
      if (done_w[0]) req_v[0] = 1'b0;
    end
    req_v = 2'b00;

    // MEM_LAT=1 instance: back-to-back reads from port 0
    begin
      int rc, k, gprev;
      logic raise;
      k = 0; gprev = -1; raise = 1'b0;
      @(posedge clk); #2;
      b_req = 1'b1; b_addr = 32'h40; rc = cyc;
      for (int i = 0; i < 40 && k < 3; i++) begin
        @(posedge clk); #2;
        chk("lat1_other_port", 32'({b1_gnt, b1_done, b_mem_we}), 32'h0);
        if (b_gnt) begin
          if (gprev >= 0) chk("lat1_gnt_spacing", 32'(cyc - gprev), 32'd3);
          chk("lat1_gnt_lat", 32'(cyc - rc), 32'd1);
          gprev = cyc;
        end
        if (b_done) begin
          chk("lat1_done_lat", 32'(cyc - rc), 32'd2);
          chk("lat1_rdata", b_rdata, b_addr ^ 32'h5A5A_0000);
          b_req = 1'b0;
          k++;
          raise = (k < 3);
        end else if (raise) begin
          b_req = 1'b1; b_addr = b_addr + 32'd4; rc = cyc; raise = 1'b0;
        end
      end
      b_req = 1'b0;
      chk("lat1_count", 32'(k), 32'd3);
    end

    // random traffic, including early req drop and field changes after grant
    pend = 2'b00; granted = 2'b00; nd = 0;
    for (int i = 0; i < 1700; i++) begin
      @(posedge clk); #2;
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          if (done_w[p]) begin
            pend[p] = 1'b0; granted[p] = 1'b0; req_v[p] = 1'b0; nd++;
          end else begin
            if (gnt_w[p]) granted[p] = 1'b1;
            if (granted[p] && $urandom_range(0, 5) == 0) begin
              we_v[p] = 1'($urandom); addr_v[p] = $urandom; wdata_v[p] = $urandom;
            end
            if (granted[p] && $urandom_range(0, 9) == 0) req_v[p] = 1'b0;
          end
        end else if (i < 1600 && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1; req_v[p] = 1'b1; we_v[p] = 1'($urandom);
          addr_v[p] = 32'($urandom_range(0, 15)) << 2;
          wdata_v[p] = $urandom;
        end
      end
    end
    req_v = 2'b00;
    chk("rand_drained", 32'(pend), 32'h0);
    chk("rand_progress", 32'(nd > 100), 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory of the single-cycle RISC-V core between two requesters: port 0 (CPU load/store path, stalled by its control logic) and port 1 (debug/test loader).
- Uses a req/gnt/done handshake with round-robin priority and a fixed memory access latency.
- Sits between the requesters and the data memory instance inside the top-level CPU wrapper.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, memory access cycles per transaction; legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- start  input  1  asynchronous active-low reset; 0 = reset, 1 = run
- r0_req  input  1  port 0 request; hold high with fields stable until r0_done
- r0_we  input  1  port 0 write enable (1 = write, 0 = read)
- r0_addr  input  AW  port 0 byte address
- r0_wdata  input  DW  port 0 write data
- r0_gnt  output  1  port 0 granted; one-cycle pulse
- r0_done  output  1  port 0 transaction complete; one-cycle pulse
- r0_rdata  output  DW  port 0 read data; valid from r0_done onward
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_done, r1_rdata: same as port 0, for port 1
- mem_en  output  1  memory enable
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data; valid at the last cycle of the access window
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (start=0, asynchronous):
  - state=IDLE, cnt=0, last=1 (so port 0 wins the first tie).
  - All outputs are 0, including rdata registers.
  - A reset mid-access aborts the access immediately: mem_en drops and no done is issued. Partial memory write is undefined.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: sample r0_req and r1_req each cycle.
  - Neither: stay in IDLE.
  - One: select it.
  - Both: select the port != last.
  - On selection (edge ending cycle N):
    - state=ACCESS, cnt=MEM_LAT-1, sel=port.
    - gnt_sel=1 for cycle N+1 only.
    - mem_en=1; mem_we/mem_addr/mem_wdata latched from the selected port.
- ACCESS: mem_* outputs are held constant for the whole access.
  - cnt!=0: cnt decrements.
  - cnt==0: if the transaction is a read, capture mem_rdata into rdata_sel. Then state=DONE, mem_en=0, mem_we=0, done_sel=1, last=sel.
- DONE: done_sel is high for exactly this one cycle; then state=IDLE.
  - req inputs are ignored in DONE.
  - The requester must drop req during the done cycle. A req still high when IDLE resumes is a new request.
- Timing:
  - req seen at N → gnt at N+1 → mem_en high cycles N+1..N+MEM_LAT → done at N+MEM_LAT+1 → IDLE at N+MEM_LAT+2.
  - Minimum spacing between grants is MEM_LAT+2 cycles.
- Writes: rdata_sel is unchanged; done still pulses.
- Request deasserted during ACCESS: ignored; the transaction completes normally.
- Request fields changed during ACCESS: no effect, because they were latched at grant.
- The unselected port sees gnt=0 and done=0. Its request waits in IDLE and wins the next tie.
- rdata registers hold their value until the next read completion on the same port.

Test Plan:
- Reset: start=0 for 10 ns with random inputs → all outputs 0, busy=0. Release start; r0 and r1 req together → r0 is granted first.
- Single read, MEM_LAT=2: r0 reads addr 0x10, mem returns 0xDEADBEEF → gnt at N+1, mem_en cycles N+1..N+2, done at N+3, r0_rdata=0xDEADBEEF, busy low at N+4.
- Contention: r0 and r1 hold req continuously (re-raised after done) for 4 transactions → grant order 0,1,0,1; no overlapping mem_en windows.
- Write then read: r1 writes 0x12345678 to 0x20, then r0 reads 0x20 → mem_we=1 only during the write window; r1_rdata unchanged; r0_rdata=0x12345678.
- Reset mid-access: start=0 in the second ACCESS cycle → mem_en=0 and gnt/done=0 immediately. After release, a new r1 request is served normally with last=1, so r0 wins the next tie.
- MEM_LAT=1 build: back-to-back r0 reads → done exactly 2 cycles after req sampled; grants spaced 3 cycles.
